// File: rtl/lutram_read_checker.sv
// Read-pass scoreboard for a LUTRAM primitive test: checks each address/data beat
// against an expected pattern, counts faults and reports done/pass.
//
// state  | meaning
// IDLE   | after reset, waiting for start_i
// CHECK  | pass in progress, accepting beats on rd_valid_i
// DONE   | 2**A_WIDTH beats accepted, results held until next start_i
module lutram_read_checker #(
    parameter int A_WIDTH   = 7,
    parameter int D_WIDTH   = 1,
    parameter int PATTERN   = 0,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 rd_valid_i,
    input  logic [A_WIDTH-1:0]   rd_addr_i,
    input  logic [D_WIDTH-1:0]   rd_data_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [CNT_WIDTH-1:0] err_count_o,
    output logic                 seq_err_o,
    output logic                 first_err_vld_o,
    output logic [A_WIDTH-1:0]   first_err_addr_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [A_WIDTH:0]     LAST_BEAT = {1'b0, {A_WIDTH{1'b1}}};
    localparam logic [A_WIDTH:0]     BEAT_ONE  = (A_WIDTH+1)'(1);
    localparam logic [A_WIDTH-1:0]   ADDR_ONE  = A_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic                 seq_err_q, seq_err_d;
    logic                 first_err_vld_q, first_err_vld_d;
    logic [A_WIDTH-1:0]   first_err_addr_q, first_err_addr_d;
    logic [A_WIDTH-1:0]   exp_addr_q, exp_addr_d;
    logic [A_WIDTH:0]     beat_cnt_q, beat_cnt_d;

    logic [D_WIDTH-1:0]   exp_data;
    logic                 accept;
    logic                 last_beat;
    logic                 arm;

    always_comb begin
        case (PATTERN)
            0:       exp_data = {D_WIDTH{rd_addr_i[0]}};
            1:       exp_data = '0;
            2:       exp_data = '1;
            default: exp_data = D_WIDTH'(rd_addr_i);
        endcase
    end

    assign accept    = (state_q == ST_CHECK) && rd_valid_i;
    assign last_beat = (beat_cnt_q == LAST_BEAT);
    assign arm       = start_i && (state_q != ST_CHECK);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= ST_IDLE;
            err_count_q      <= '0;
            seq_err_q        <= 1'b0;
            first_err_vld_q  <= 1'b0;
            first_err_addr_q <= '0;
            exp_addr_q       <= '0;
            beat_cnt_q       <= '0;
        end else begin
            state_q          <= state_d;
            err_count_q      <= err_count_d;
            seq_err_q        <= seq_err_d;
            first_err_vld_q  <= first_err_vld_d;
            first_err_addr_q <= first_err_addr_d;
            exp_addr_q       <= exp_addr_d;
            beat_cnt_q       <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_CHECK;
            ST_CHECK: if (accept && last_beat) state_d = ST_DONE;
            ST_DONE:  if (start_i) state_d = ST_CHECK;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        err_count_d      = err_count_q;
        seq_err_d        = seq_err_q;
        first_err_vld_d  = first_err_vld_q;
        first_err_addr_d = first_err_addr_q;
        exp_addr_d       = exp_addr_q;
        beat_cnt_d       = beat_cnt_q;
        if (arm) begin
            err_count_d      = '0;
            seq_err_d        = 1'b0;
            first_err_vld_d  = 1'b0;
            first_err_addr_d = '0;
            exp_addr_d       = '0;
            beat_cnt_d       = '0;
        end else if (accept) begin
            if (rd_data_i != exp_data) begin
                if (err_count_q != CNT_MAX) err_count_d = err_count_q + CNT_ONE;
                if (!first_err_vld_q) begin
                    first_err_vld_d  = 1'b1;
                    first_err_addr_d = rd_addr_i;
                end
            end
            if (rd_addr_i != exp_addr_q) seq_err_d = 1'b1;
            // Track the address actually seen so a single skip flags once, then re-syncs.
            exp_addr_d = rd_addr_i + ADDR_ONE;
            beat_cnt_d = beat_cnt_q + BEAT_ONE;
        end
    end

    always_comb begin
        busy_o = (state_q == ST_CHECK);
        done_o = (state_q == ST_DONE);
        pass_o = (state_q == ST_DONE) && (err_count_q == '0) && !seq_err_q;
    end

    assign err_count_o      = err_count_q;
    assign seq_err_o        = seq_err_q;
    assign first_err_vld_o  = first_err_vld_q;
    assign first_err_addr_o = first_err_addr_q;

endmodule

// File: tb/tb_lutram_read_checker.sv
// Bench for lutram_read_checker: a default instance and a CNT_WIDTH=4 instance share
// stimulus and are compared against a pass-level reference model.
module tb_lutram_read_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       valid = 1'b0;
    logic [6:0] addr = '0;
    logic       data = 1'b0;

    logic       busy0, done0, pass0, seq0, fvld0;
    logic [7:0] err0;
    logic [6:0] faddr0;
    logic       busy1, done1, pass1, seq1, fvld1;
    logic [3:0] err1;
    logic [6:0] faddr1;

    lutram_read_checker u_dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .rd_valid_i(valid),
        .rd_addr_i(addr), .rd_data_i(data),
        .busy_o(busy0), .done_o(done0), .pass_o(pass0), .err_count_o(err0),
        .seq_err_o(seq0), .first_err_vld_o(fvld0), .first_err_addr_o(faddr0)
    );

    lutram_read_checker #(.CNT_WIDTH(4)) u_sat (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .rd_valid_i(valid),
        .rd_addr_i(addr), .rd_data_i(data),
        .busy_o(busy1), .done_o(done1), .pass_o(pass1), .err_count_o(err1),
        .seq_err_o(seq1), .first_err_vld_o(fvld1), .first_err_addr_o(faddr1)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: pass status in plain integers.
    bit m_busy, m_done, m_seq, m_fvld;
    int m_err, m_faddr, m_next, m_beats;

    wire [19:0] obs0 = {busy0, done0, pass0, seq0, fvld0, faddr0, err0};
    wire [15:0] obs1 = {busy1, done1, pass1, seq1, fvld1, faddr1, err1};

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_seq = 0; m_fvld = 0;
        m_err = 0; m_faddr = 0; m_next = 0; m_beats = 0;
    endtask

    task automatic model_edge(input bit s, input bit v, input int a, input bit d);
        if (!m_busy) begin
            if (s) begin
                model_reset();
                m_busy = 1;
            end
        end else if (v) begin
            if (d != bit'(a % 2)) begin
                m_err++;
                if (!m_fvld) begin
                    m_fvld  = 1;
                    m_faddr = a;
                end
            end
            if (a != m_next) m_seq = 1;
            m_next = (a + 1) % 128;
            m_beats++;
            if (m_beats == 128) begin
                m_busy = 0;
                m_done = 1;
            end
        end
    endtask

    function automatic bit m_pass();
        return m_done && (m_err == 0) && !m_seq;
    endfunction

    function automatic logic [19:0] exp0();
        int e = (m_err > 255) ? 255 : m_err;
        return {m_busy, m_done, m_pass(), m_seq, m_fvld, 7'(m_faddr), 8'(e)};
    endfunction

    function automatic logic [15:0] exp1();
        int e = (m_err > 15) ? 15 : m_err;
        return {m_busy, m_done, m_pass(), m_seq, m_fvld, 7'(m_faddr), 4'(e)};
    endfunction

    task automatic cycle(input bit s, input bit v, input int a, input bit d);
        @(negedge clk);
        start = s; valid = v; addr = 7'(a); data = d;
        @(posedge clk);
        if (rst_n) model_edge(s, v, a, d);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_total++;
        if (obs0 !== 20'h0 || obs1 !== 16'h0)
            $display("FAIL reset_initial: got %h/%h want 0/0", obs0, obs1);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) cycle(0, 1, i, ~bit'(i % 2));
        n_total++;
        if (obs0 !== exp0() || obs1 !== exp1() || obs0 !== 20'h0)
            $display("FAIL idle_valid_ignored: got %h/%h want %h/%h", obs0, obs1, exp0(), exp1());
        else n_pass++;
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 1, i, ~bit'(i % 2));
        @(posedge clk);
        #($urandom_range(1, 3));
        rst_n = 1'b0;
        #1;
        n_total++;
        if (obs0 !== 20'h0 || obs1 !== 16'h0)
            $display("FAIL reset_async: got %h/%h want 0/0", obs0, obs1);
        else n_pass++;
        model_reset();
        cycle(0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 0, 0, 0);
        n_total++;
        if (obs0 !== exp0() || obs1 !== exp1())
            $display("FAIL reset_release: got %h/%h want %h/%h", obs0, obs1, exp0(), exp1());
        else n_pass++;
    endtask

    task automatic test_clean_pass();
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 128; i++) begin
            cycle(0, 1, i, bit'(i % 2));
            if (i == 126) begin
                n_total++;
                if (obs0 !== exp0() || busy0 !== 1'b1 || done0 !== 1'b0)
                    $display("FAIL clean_beat126: got %h want %h", obs0, exp0());
                else n_pass++;
            end
        end
        n_total++;
        if (obs0 !== exp0() || obs1 !== exp1() || done0 !== 1'b1 || busy0 !== 1'b0 ||
            pass0 !== 1'b1 || err0 !== 8'd0)
            $display("FAIL clean_done: got %h/%h want %h/%h", obs0, obs1, exp0(), exp1());
        else n_pass++;
    endtask

    task automatic test_single_fault();
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 128; i++)
            cycle(0, 1, i, (i == 37) ? ~bit'(i % 2) : bit'(i % 2));
        n_total++;
        if (obs0 !== exp0() || err0 !== 8'd1 || faddr0 !== 7'd37 || fvld0 !== 1'b1 ||
            pass0 !== 1'b0 || done0 !== 1'b1)
            $display("FAIL single_fault: got %h want %h", obs0, exp0());
        else n_pass++;
    endtask

    task automatic test_saturation();
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 128; i++) begin
            cycle(0, 1, i, ~bit'(i % 2));
            if (i == 14 || i == 15) begin
                n_total++;
                if (obs1 !== exp1())
                    $display("FAIL sat_edge%0d: got %h want %h", i, obs1, exp1());
                else n_pass++;
            end
        end
        n_total++;
        if (obs1 !== exp1() || err1 !== 4'd15 || faddr1 !== 7'd0 || pass1 !== 1'b0 ||
            obs0 !== exp0() || err0 !== 8'd128)
            $display("FAIL saturation: got %h/%h want %h/%h", obs0, obs1, exp0(), exp1());
        else n_pass++;
    endtask

    task automatic test_sequence();
        int a;
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 128; i++) begin
            a = ((i < 5) ? i : i + 1) % 128;
            cycle(0, 1, a, bit'(a % 2));
            if (i == 5) begin
                n_total++;
                if (obs0 !== exp0() || seq0 !== 1'b1)
                    $display("FAIL seq_skip: got %h want %h", obs0, exp0());
                else n_pass++;
            end
        end
        n_total++;
        if (obs0 !== exp0() || seq0 !== 1'b1 || err0 !== 8'd0 || pass0 !== 1'b0 || done0 !== 1'b1)
            $display("FAIL sequence: got %h want %h", obs0, exp0());
        else n_pass++;
    endtask

    task automatic test_robustness();
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 128; i++) begin
            if ($urandom_range(0, 3) == 0) cycle(0, 0, 0, 0);
            cycle(i == 50, 1, i, bit'(i % 2));
            if (i == 50) begin
                n_total++;
                if (obs0 !== exp0() || busy0 !== 1'b1)
                    $display("FAIL start_in_check: got %h want %h", obs0, exp0());
                else n_pass++;
            end
        end
        n_total++;
        if (obs0 !== exp0() || done0 !== 1'b1 || pass0 !== 1'b1)
            $display("FAIL start_ignored_done: got %h want %h", obs0, exp0());
        else n_pass++;
        for (int i = 0; i < 5; i++) cycle(0, 1, i, ~bit'(i % 2));
        n_total++;
        if (obs0 !== exp0() || obs1 !== exp1())
            $display("FAIL done_hold: got %h/%h want %h/%h", obs0, obs1, exp0(), exp1());
        else n_pass++;
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 60; i++) cycle(0, 1, i, ~bit'(i % 2));
        @(negedge clk);
        rst_n = 1'b0;
        valid = 1'b0;
        model_reset();
        #1;
        n_total++;
        if (obs0 !== 20'h0 || obs1 !== 16'h0)
            $display("FAIL reset_beat60: got %h/%h want 0/0", obs0, obs1);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 128; i++) cycle(0, 1, i, bit'(i % 2));
        n_total++;
        if (obs0 !== exp0() || pass0 !== 1'b1 || done0 !== 1'b1)
            $display("FAIL restart_clean: got %h want %h", obs0, exp0());
        else n_pass++;
    endtask

    task automatic test_random();
        int a;
        bit d;
        for (int p = 0; p < 4; p++) begin
            cycle(1, 0, 0, 0);
            a = 0;
            while (m_busy) begin
                if ($urandom_range(0, 4) == 0) begin
                    cycle($urandom_range(0, 1), 0, $urandom_range(0, 127), 0);
                end else begin
                    if ($urandom_range(0, 40) == 0) a = $urandom_range(0, 127);
                    d = bit'(a % 2);
                    if ($urandom_range(0, 15) == 0) d = ~d;
                    cycle($urandom_range(0, 9) == 0, 1, a, d);
                    a = (a + 1) % 128;
                end
                n_total++;
                if (obs0 !== exp0() || obs1 !== exp1())
                    $display("FAIL random_p%0d: got %h/%h want %h/%h", p, obs0, obs1, exp0(), exp1());
                else n_pass++;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_pass();
        test_single_fault();
        test_saturation();
        test_sequence();
        test_robustness();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
